// File: rtl/pattern_vg_pkg.sv
// Shared mode codes, pipeline latency and colour-bar palette for the
// multi-channel test-pattern generator.
package pattern_vg_pkg;

  typedef enum logic [7:0] {
    PAT_PASS    = 8'd0,
    PAT_BORDER  = 8'd1,
    PAT_MOIRE_X = 8'd2,
    PAT_MOIRE_Y = 8'd3,
    PAT_HRAMP   = 8'd4,
    PAT_VRAMP   = 8'd5,
    PAT_BARS    = 8'd6,
    PAT_CHECK   = 8'd7,
    PAT_SOLID   = 8'd8,
    PAT_SCROLL  = 8'd9
  } pat_mode_e;

  localparam int LATENCY = 2;

  // rgb is {R,G,B}; index 0..7 walks white, yellow, cyan, green, magenta, red, blue, black
  function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
    return {~idx[1], ~idx[2], ~idx[0]};
  endfunction

endpackage

// File: rtl/pattern_vg_multi_if.sv
// Video bus between timing generator, pattern generator and output formatter.
interface pattern_vg_multi_if #(
  parameter int B               = 8,
  parameter int NUM_CH          = 3,
  parameter int X_BITS          = 13,
  parameter int Y_BITS          = 13,
  parameter int FRACTIONAL_BITS = 12,
  parameter int FCNT_BITS       = 16
);
  logic [X_BITS-1:0]            x;
  logic [Y_BITS-1:0]            y;
  logic                         vn_in;
  logic                         hn_in;
  logic                         dn_in;
  logic [NUM_CH*B-1:0]          pix_in;
  logic [X_BITS-1:0]            total_active_pix;
  logic [Y_BITS-1:0]            total_active_lines;
  logic [7:0]                   pattern;
  logic [B+FRACTIONAL_BITS-1:0] ramp_step;
  logic [NUM_CH*B-1:0]          solid_color;
  logic                         vn_out;
  logic                         hn_out;
  logic                         den_out;
  logic [NUM_CH*B-1:0]          pix_out;
  logic [FCNT_BITS-1:0]         frame_cnt;

  modport master (
    output x, y, vn_in, hn_in, dn_in, pix_in, total_active_pix, total_active_lines,
           pattern, ramp_step, solid_color,
    input  vn_out, hn_out, den_out, pix_out, frame_cnt
  );

  modport slave (
    input  x, y, vn_in, hn_in, dn_in, pix_in, total_active_pix, total_active_lines,
           pattern, ramp_step, solid_color,
    output vn_out, hn_out, den_out, pix_out, frame_cnt
  );
endinterface

// File: rtl/pattern_vg_ramp_acc.sv
// Wrapping fixed-point accumulator; a load takes priority over a step.
module pattern_vg_ramp_acc #(
  parameter int W = 20
) (
  input  logic         clk_in,
  input  logic         reset,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] step,
  output logic [W-1:0] acc
);
  logic [W-1:0] acc_d, acc_q;

  always_comb begin
    acc_d = acc_q;
    if (load) begin
      acc_d = load_val;
    end else if (en) begin
      acc_d = acc_q + step;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;
endmodule

// File: rtl/pattern_vg_multi.sv
// Multi-channel test-pattern generator: ten modes latched at frame start,
// fixed two-cycle latency on pixels, syncs and the frame counter.
module pattern_vg_multi
  import pattern_vg_pkg::*;
#(
  parameter int B               = 8,
  parameter int NUM_CH          = 3,
  parameter int X_BITS          = 13,
  parameter int Y_BITS          = 13,
  parameter int FRACTIONAL_BITS = 12,
  parameter int CHECK_LOG2      = 4,
  parameter int FCNT_BITS       = 16
) (
  input  logic              clk_in,
  input  logic              reset,
  pattern_vg_multi_if.slave vif
);
  localparam int W     = B + FRACTIONAL_BITS;
  localparam int PIX_W = NUM_CH * B;
  localparam logic [PIX_W-1:0] WHITE = '1;

  function automatic logic [PIX_W-1:0] expand_rgb(input logic [2:0] rgb);
    logic [PIX_W-1:0] p;
    logic [1:0]       sel;
    p = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      sel = 2'(2 - (k % 3));
      p[PIX_W-1-k*B -: B] = {B{rgb[sel]}};
    end
    return p;
  endfunction

  // Integer part of the accumulator drives every channel.
  function automatic logic [PIX_W-1:0] ramp_pix(input logic [W-1:0] v);
    return {NUM_CH{v[W-1:FRACTIONAL_BITS]}};
  endfunction

  logic [X_BITS-1:0] x_last, bar_w;
  logic [Y_BITS-1:0] y_last;
  logic              x_first, fs, line_end, fe, h_load;
  logic [7:0]        mode_cur, mode_d, mode_q;
  logic [W-1:0]      h_base, h_load_val, h_acc, v_acc, scroll_off, h_val, v_val;
  logic [X_BITS-1:0] bar_cnt_cur, bar_cnt_d, bar_cnt_q;
  logic [2:0]        bar_idx_cur, bar_idx_eff, bar_idx_d, bar_idx_q;
  logic [FCNT_BITS-1:0] fcnt_d, fcnt_q, fcnt_p2_d, fcnt_p2_q;
  logic [PIX_W-1:0]  pix_p1_d, pix_p1_q, pix_p2_d, pix_p2_q;
  logic              vn_p1_d, vn_p1_q, hn_p1_d, hn_p1_q, de_p1_d, de_p1_q;
  logic              vn_p2_d, vn_p2_q, hn_p2_d, hn_p2_q, de_p2_d, de_p2_q;

  assign x_last   = vif.total_active_pix - X_BITS'(1);
  assign y_last   = vif.total_active_lines - Y_BITS'(1);
  assign x_first  = (vif.x == '0);
  assign fs       = vif.dn_in && x_first && (vif.y == '0);
  assign line_end = vif.dn_in && (vif.x == x_last);
  assign fe       = line_end && (vif.y == y_last);
  // The FS pixel itself already renders in the newly requested mode.
  assign mode_cur = fs ? vif.pattern : mode_q;

  // Column accumulator holds the value for x+1; x==0 uses the base directly.
  assign h_base     = (mode_cur == PAT_SCROLL) ? scroll_off : '0;
  assign h_load     = vif.dn_in && x_first;
  assign h_load_val = h_base + vif.ramp_step;
  assign h_val      = x_first ? h_base : h_acc;
  assign v_val      = fs ? '0 : v_acc;

  pattern_vg_ramp_acc #(.W(W)) u_h_acc (
    .clk_in(clk_in), .reset(reset), .en(vif.dn_in), .load(h_load),
    .load_val(h_load_val), .step(vif.ramp_step), .acc(h_acc)
  );

  pattern_vg_ramp_acc #(.W(W)) u_v_acc (
    .clk_in(clk_in), .reset(reset), .en(line_end), .load(fs),
    .load_val('0), .step(vif.ramp_step), .acc(v_acc)
  );

  pattern_vg_ramp_acc #(.W(W)) u_scroll (
    .clk_in(clk_in), .reset(reset), .en(fe), .load(1'b0),
    .load_val('0), .step(vif.ramp_step), .acc(scroll_off)
  );

  always_comb begin
    mode_d = mode_cur;
    fcnt_d = fe ? fcnt_q + FCNT_BITS'(1) : fcnt_q;

    // Bar index counts whole bars from x==0 and parks on the last bar.
    bar_w       = vif.total_active_pix >> 3;
    bar_cnt_cur = x_first ? '0 : bar_cnt_q;
    bar_idx_cur = x_first ? '0 : bar_idx_q;
    bar_idx_eff = (bar_w == '0) ? 3'd7 : bar_idx_cur;
    bar_cnt_d   = bar_cnt_q;
    bar_idx_d   = bar_idx_q;
    if (vif.dn_in) begin
      if (bar_cnt_cur + X_BITS'(1) == bar_w) begin
        bar_cnt_d = '0;
        bar_idx_d = (bar_idx_cur == 3'd7) ? 3'd7 : bar_idx_cur + 3'd1;
      end else begin
        bar_cnt_d = bar_cnt_cur + X_BITS'(1);
        bar_idx_d = bar_idx_cur;
      end
    end

    // Stage 0 -> p1: pattern select
    pix_p1_d = vif.pix_in;
    if (!vif.dn_in) begin
      if ((mode_cur != PAT_PASS) && (mode_cur <= PAT_SCROLL)) pix_p1_d = '0;
    end else begin
      case (mode_cur)
        PAT_BORDER: begin
          if (x_first || (vif.y == '0) || (vif.x == x_last) || (vif.y == y_last))
            pix_p1_d = WHITE;
        end
        PAT_MOIRE_X: pix_p1_d = {PIX_W{vif.x[0]}};
        PAT_MOIRE_Y: pix_p1_d = {PIX_W{vif.y[0]}};
        PAT_HRAMP:   pix_p1_d = ramp_pix(h_val);
        PAT_VRAMP:   pix_p1_d = ramp_pix(v_val);
        PAT_BARS:    pix_p1_d = expand_rgb(bar_rgb(bar_idx_eff));
        PAT_CHECK:   pix_p1_d = {PIX_W{vif.x[CHECK_LOG2] ^ vif.y[CHECK_LOG2]}};
        PAT_SOLID:   pix_p1_d = vif.solid_color;
        PAT_SCROLL:  pix_p1_d = ramp_pix(h_val);
        default:     pix_p1_d = vif.pix_in;
      endcase
    end
    vn_p1_d = vif.vn_in;
    hn_p1_d = vif.hn_in;
    de_p1_d = vif.dn_in;

    // p1 -> p2: output register
    pix_p2_d  = pix_p1_q;
    vn_p2_d   = vn_p1_q;
    hn_p2_d   = hn_p1_q;
    de_p2_d   = de_p1_q;
    fcnt_p2_d = fcnt_q;
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      mode_q    <= '0;
      bar_cnt_q <= '0;
      bar_idx_q <= '0;
      fcnt_q    <= '0;
      pix_p1_q  <= '0;
      vn_p1_q   <= 1'b0;
      hn_p1_q   <= 1'b0;
      de_p1_q   <= 1'b0;
      pix_p2_q  <= '0;
      vn_p2_q   <= 1'b0;
      hn_p2_q   <= 1'b0;
      de_p2_q   <= 1'b0;
      fcnt_p2_q <= '0;
    end else begin
      mode_q    <= mode_d;
      bar_cnt_q <= bar_cnt_d;
      bar_idx_q <= bar_idx_d;
      fcnt_q    <= fcnt_d;
      pix_p1_q  <= pix_p1_d;
      vn_p1_q   <= vn_p1_d;
      hn_p1_q   <= hn_p1_d;
      de_p1_q   <= de_p1_d;
      pix_p2_q  <= pix_p2_d;
      vn_p2_q   <= vn_p2_d;
      hn_p2_q   <= hn_p2_d;
      de_p2_q   <= de_p2_d;
      fcnt_p2_q <= fcnt_p2_d;
    end
  end

  assign vif.pix_out   = pix_p2_q;
  assign vif.vn_out    = vn_p2_q;
  assign vif.hn_out    = hn_p2_q;
  assign vif.den_out   = de_p2_q;
  assign vif.frame_cnt = fcnt_p2_q;
endmodule

// File: tb/tb_pattern_vg_multi.sv
// Scoreboard bench for pattern_vg_multi: the driver queues the expected output
// for every input cycle, a negedge monitor pops and compares.
module tb_pattern_vg_multi;
  import pattern_vg_pkg::*;

  localparam int B = 8, NUM_CH = 3, XB = 13, YB = 13, F = 12, CL = 4, FB = 16;
  localparam int W = B + F;

  localparam logic [23:0] BAR_TAB [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                         24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  typedef struct {
    int          due;
    logic        vn, hn, de;
    logic [23:0] pix;
    logic [15:0] fc;
  } exp_t;

  logic clk_in = 1'b0;
  logic reset  = 1'b1;
  always #5 clk_in = ~clk_in;

  pattern_vg_multi_if #(.B(B), .NUM_CH(NUM_CH), .X_BITS(XB), .Y_BITS(YB),
                        .FRACTIONAL_BITS(F), .FCNT_BITS(FB)) vif ();

  pattern_vg_multi #(.B(B), .NUM_CH(NUM_CH), .X_BITS(XB), .Y_BITS(YB),
                     .FRACTIONAL_BITS(F), .CHECK_LOG2(CL), .FCNT_BITS(FB))
    dut (.clk_in(clk_in), .reset(reset), .vif(vif));

  exp_t q[$];
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  logic [7:0]    mode_m   = '0;
  logic [W-1:0]  scroll_m = '0;
  logic [FB-1:0] fc_m     = '0;

  always @(posedge clk_in) cyc <= cyc + 1;

  // Monitor
  always @(negedge clk_in) begin
    exp_t e;
    while (q.size() > 0 && q[0].due < cyc) begin
      e = q.pop_front();
      checks++;
      failures++;
      $display("FAIL missed_sample due=%0d now=%0d", e.due, cyc);
    end
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      checks++;
      if ({vif.vn_out, vif.hn_out, vif.den_out, vif.pix_out, vif.frame_cnt} !==
          {e.vn, e.hn, e.de, e.pix, e.fc}) begin
        failures++;
        if (failures <= 25)
          $display("FAIL out cyc=%0d actual vn=%b hn=%b de=%b pix=%06h fc=%0d required vn=%b hn=%b de=%b pix=%06h fc=%0d",
                   cyc, vif.vn_out, vif.hn_out, vif.den_out, vif.pix_out, vif.frame_cnt,
                   e.vn, e.hn, e.de, e.pix, e.fc);
      end
    end
  end

  function automatic logic [23:0] model_pix(input logic [7:0] m, input logic dn,
                                            input int xx, input int yy, input logic [23:0] pin);
    int tap, tal, bw, bi;
    logic [W-1:0] v;
    tap = int'(vif.total_active_pix);
    tal = int'(vif.total_active_lines);
    if (!dn) return (m == 8'd0 || m > 8'd9) ? pin : 24'h0;
    case (m)
      8'd1: return (xx == 0 || yy == 0 || xx == tap - 1 || yy == tal - 1) ? 24'hFFFFFF : pin;
      8'd2: return (xx % 2 == 1) ? 24'hFFFFFF : 24'h0;
      8'd3: return (yy % 2 == 1) ? 24'hFFFFFF : 24'h0;
      8'd4, 8'd9: begin
        v = W'(longint'(xx) * longint'(vif.ramp_step));
        if (m == 8'd9) v = v + scroll_m;
        return {3{v[W-1:F]}};
      end
      8'd5: begin
        v = W'(longint'(yy) * longint'(vif.ramp_step));
        return {3{v[W-1:F]}};
      end
      8'd6: begin
        bw = tap / 8;
        bi = (bw == 0) ? 7 : xx / bw;
        if (bi > 7) bi = 7;
        return BAR_TAB[bi];
      end
      8'd7: return ((((xx >> CL) ^ (yy >> CL)) & 1) == 1) ? 24'hFFFFFF : 24'h0;
      8'd8: return vif.solid_color;
      default: return pin;
    endcase
  endfunction

  task automatic drive(input logic r, input logic vn, input logic hn, input logic dn,
                       input int xx, input int yy);
    exp_t e, last;
    logic [23:0] pin;
    logic fs, fe;
    @(posedge clk_in);
    #1;
    pin = 24'($urandom);
    reset = r;
    vif.vn_in = vn; vif.hn_in = hn; vif.dn_in = dn;
    vif.x = XB'(xx); vif.y = YB'(yy); vif.pix_in = pin;
    e.due = cyc + LATENCY;
    if (r) begin
      // The output register is cleared one edge after reset is seen.
      if (q.size() > 0) begin
        last = q.pop_back();
        last.vn = 1'b0; last.hn = 1'b0; last.de = 1'b0; last.pix = '0; last.fc = '0;
        q.push_back(last);
      end
      mode_m = '0; scroll_m = '0; fc_m = '0;
      e.vn = 1'b0; e.hn = 1'b0; e.de = 1'b0; e.pix = '0; e.fc = '0;
    end else begin
      fs = dn && xx == 0 && yy == 0;
      fe = dn && xx == int'(vif.total_active_pix) - 1 && yy == int'(vif.total_active_lines) - 1;
      if (fs) mode_m = vif.pattern;
      e.pix = model_pix(mode_m, dn, xx, yy, pin);
      if (fe) begin
        fc_m++;
        scroll_m = scroll_m + vif.ramp_step;
      end
      e.vn = vn; e.hn = hn; e.de = dn; e.fc = fc_m;
    end
    q.push_back(e);
  endtask

  task automatic run_frame(input int rst_at, input int pat_at, input logic [7:0] pat_new);
    int n;
    n = 0;
    for (int yy = 0; yy < int'(vif.total_active_lines); yy++) begin
      for (int xx = 0; xx < int'(vif.total_active_pix); xx++) begin
        if (n == pat_at) vif.pattern = pat_new;
        drive(rst_at >= 0 && (n == rst_at || n == rst_at + 1), 1'b0, 1'b0, 1'b1, xx, yy);
        n++;
      end
      for (int h = 0; h < 3; h++) drive(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    end
    for (int v = 0; v < 4; v++) drive(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vif.x = '0; vif.y = '0; vif.vn_in = 1'b0; vif.hn_in = 1'b0; vif.dn_in = 1'b0;
    vif.pix_in = '0; vif.total_active_pix = 13'd16; vif.total_active_lines = 13'd8;
    vif.pattern = 8'd4; vif.ramp_step = 20'h10000; vif.solid_color = 24'h123456;

    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 2; i++) drive(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);

    // Horizontal ramp, then reset mid-line (line 3, x 5), then ramp again
    run_frame(-1, -1, 8'd0);
    run_frame(53, -1, 8'd0);
    run_frame(-1, -1, 8'd0);

    vif.pattern = 8'd5;   run_frame(-1, -1, 8'd0);
    vif.pattern = 8'd6;   run_frame(-1, -1, 8'd0);
    vif.total_active_pix = 13'd20; run_frame(-1, -1, 8'd0);
    vif.total_active_pix = 13'd4;  run_frame(-1, -1, 8'd0);
    vif.total_active_pix = 13'd16;
    vif.pattern = 8'd1;   run_frame(-1, -1, 8'd0);
    vif.pattern = 8'd2;   run_frame(-1, -1, 8'd0);
    vif.pattern = 8'd3;   run_frame(-1, -1, 8'd0);
    vif.pattern = 8'd8;   run_frame(-1, -1, 8'd0);
    vif.pattern = 8'd200; run_frame(-1, -1, 8'd0);
    vif.pattern = 8'd0;   run_frame(-1, -1, 8'd0);

    // Mode 4 -> 7 requested mid-frame takes effect at the next frame start
    vif.pattern = 8'd4;   run_frame(-1, -1, 8'd0);
    run_frame(-1, 70, 8'd7);
    run_frame(-1, -1, 8'd0);
    vif.total_active_pix = 13'd40; vif.total_active_lines = 13'd20;
    run_frame(-1, -1, 8'd0);

    // Scrolling ramp from a fresh reset: frame n starts at 8n, 32 frames wrap
    vif.total_active_pix = 13'd16; vif.total_active_lines = 13'd8;
    vif.ramp_step = 20'h08000; vif.pattern = 8'd9;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    for (int f = 0; f < 33; f++) run_frame(-1, -1, 8'd0);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk_in);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    @(negedge clk_in);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
